// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing controller: op codes, state encoding
// and default operand/accumulator widths.
package mac_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 2*DEF_DATA_W + 1;

   localparam logic OP_SOP = 1'b0;
   localparam logic OP_TRI = 1'b1;

   localparam logic [2:0] ENC_IDLE    = 3'd0;
   localparam logic [2:0] ENC_ISSUE1  = 3'd1;
   localparam logic [2:0] ENC_ISSUE2  = 3'd2;
   localparam logic [2:0] ENC_CAPTURE = 3'd3;
   localparam logic [2:0] ENC_DONE    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = ENC_IDLE,
      ST_ISSUE1  = ENC_ISSUE1,
      ST_ISSUE2  = ENC_ISSUE2,
      ST_CAPTURE = ENC_CAPTURE,
      ST_DONE    = ENC_DONE
   } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Initiator for an external MAC unit: takes one job per handshake, drives the MAC
// over two issue cycles, captures its registered output and holds it for the consumer.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic              job_op,
   input  logic [DATA_W-1:0] job_a,
   input  logic [DATA_W-1:0] job_x,
   input  logic [DATA_W-1:0] job_b,
   input  logic [DATA_W-1:0] job_c,
   output logic [DATA_W-1:0] mac_in_1,
   output logic [DATA_W-1:0] mac_in_2,
   output logic [DATA_W-1:0] mac_in_add,
   output logic              mac_mode,
   output logic              mac_mul_input_mux,
   output logic              mac_adder_input_mux,
   input  logic [ACC_W-1:0]  mac_output,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_op
);

   state_t            state, state_next;
   logic [DATA_W-1:0] op_a, op_x, op_b, op_c;
   logic              op_sel;

   assign job_ready = (state == ST_IDLE);
   assign res_valid = (state == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operands are captured only on the accepting edge so later job_* activity is harmless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a   <= '0;
         op_x   <= '0;
         op_b   <= '0;
         op_c   <= '0;
         op_sel <= OP_SOP;
      end else if (job_valid && job_ready) begin
         op_a   <= job_a;
         op_x   <= job_x;
         op_b   <= job_b;
         op_c   <= job_c;
         op_sel <= job_op;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_data <= '0;
         res_op   <= OP_SOP;
      end else if (state == ST_CAPTURE) begin
         res_data <= mac_output;
         res_op   <= op_sel;
      end
   end

   // TRI feeds the accumulator back into the multiplier; SOP feeds it into the adder.
   always_comb begin
      state_next          = state;
      mac_in_1            = '0;
      mac_in_2            = '0;
      mac_in_add          = '0;
      mac_mode            = 1'b0;
      mac_mul_input_mux   = 1'b0;
      mac_adder_input_mux = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (job_valid) state_next = ST_ISSUE1;
         end
         ST_ISSUE1: begin
            mac_in_1   = op_a;
            mac_in_2   = op_x;
            mac_mode   = op_sel;
            if (op_sel == OP_TRI) mac_in_add = op_b;
            state_next = ST_ISSUE2;
         end
         ST_ISSUE2: begin
            mac_mode = op_sel;
            if (op_sel == OP_TRI) begin
               mac_in_2          = op_x;
               mac_in_add        = op_c;
               mac_mul_input_mux = 1'b1;
            end else begin
               mac_in_1            = op_b;
               mac_in_2            = op_c;
               mac_adder_input_mux = 1'b1;
            end
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_next = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural MAC unit attached to its
// operand/control ports; results are compared against plain-arithmetic expectations.
module tb_mac_seq_ctrl;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 17;

   logic              clk = 1'b0;
   logic              reset;
   logic              job_valid;
   logic              job_ready;
   logic              job_op;
   logic [DATA_W-1:0] job_a, job_x, job_b, job_c;
   logic [DATA_W-1:0] mac_in_1, mac_in_2, mac_in_add;
   logic              mac_mode, mac_mul_input_mux, mac_adder_input_mux;
   logic [ACC_W-1:0]  mac_output;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;
   logic              res_op;

   int tests_run  = 0;
   int fail_count = 0;

   always #5 clk = ~clk;

   mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk                 (clk),
      .reset               (reset),
      .job_valid           (job_valid),
      .job_ready           (job_ready),
      .job_op              (job_op),
      .job_a               (job_a),
      .job_x               (job_x),
      .job_b               (job_b),
      .job_c               (job_c),
      .mac_in_1            (mac_in_1),
      .mac_in_2            (mac_in_2),
      .mac_in_add          (mac_in_add),
      .mac_mode            (mac_mode),
      .mac_mul_input_mux   (mac_mul_input_mux),
      .mac_adder_input_mux (mac_adder_input_mux),
      .mac_output          (mac_output),
      .res_valid           (res_valid),
      .res_ready           (res_ready),
      .res_data            (res_data),
      .res_op              (res_op)
   );

   // External MAC unit stand-in: registered acc = mul_src * in_2 + add_src, truncated.
   logic [ACC_W-1:0] mul_src, add_src;
   assign mul_src = mac_mul_input_mux   ? mac_output : ACC_W'(mac_in_1);
   assign add_src = mac_adder_input_mux ? mac_output : ACC_W'(mac_in_add);
   always @(posedge clk or posedge reset) begin
      if (reset) mac_output <= '0;
      else       mac_output <= ACC_W'(mul_src * ACC_W'(mac_in_2) + add_src);
   end

   function automatic int unsigned expected_result(input logic op, input int unsigned a,
      input int unsigned x, input int unsigned b, input int unsigned c);
      longint unsigned r;
      if (op) r = (a * x + b) * x + c;
      else    r = a * x + b * c;
      return int'(r % (64'd1 << ACC_W));
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed,
      input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_mac(input string tag, input int in1, input int in2, input int add,
      input logic mode, input logic mm, input logic am);
      check_output({tag, ".in_1"},  32'(mac_in_1),   32'(in1));
      check_output({tag, ".in_2"},  32'(mac_in_2),   32'(in2));
      check_output({tag, ".in_add"}, 32'(mac_in_add), 32'(add));
      check_output({tag, ".mode"},  32'(mac_mode),   32'(mode));
      check_output({tag, ".mulmux"}, 32'(mac_mul_input_mux),   32'(mm));
      check_output({tag, ".addmux"}, 32'(mac_adder_input_mux), 32'(am));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20 && job_ready !== 1'b1; i++) step();
      check_output({tag, ".job_ready"}, 32'(job_ready), 32'd1);
   endtask

   task automatic apply_stimulus(input string tag, input logic op, input logic [7:0] a,
      input logic [7:0] x, input logic [7:0] b, input logic [7:0] c, input int hold);
      int unsigned exp_res;
      exp_res = expected_result(op, a, x, b, c);
      wait_ready(tag);
      res_ready = (hold == 0);
      job_valid = 1'b1;
      job_op    = op;
      job_a = a; job_x = x; job_b = b; job_c = c;
      step();
      job_valid = 1'b0;
      job_op    = 1'($urandom);
      job_a = 8'($urandom); job_x = 8'($urandom); job_b = 8'($urandom); job_c = 8'($urandom);
      check_output({tag, ".issue1.job_ready"}, 32'(job_ready), 32'd0);
      if (op) check_mac({tag, ".issue1"}, a, x, b, 1'b1, 1'b0, 1'b0);
      else    check_mac({tag, ".issue1"}, a, x, 0, 1'b0, 1'b0, 1'b0);
      step();
      if (op) check_mac({tag, ".issue2"}, 0, x, c, 1'b1, 1'b1, 1'b0);
      else    check_mac({tag, ".issue2"}, b, c, 0, 1'b0, 1'b0, 1'b1);
      step();
      check_mac({tag, ".capture"}, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      check_output({tag, ".capture.res_valid"}, 32'(res_valid), 32'd0);
      step();
      check_output({tag, ".res_valid"}, 32'(res_valid), 32'd1);
      check_output({tag, ".res_data"},  32'(res_data),  exp_res);
      check_output({tag, ".res_op"},    32'(res_op),    32'(op));
      for (int i = 0; i < hold; i++) begin
         job_valid = 1'b1;
         step();
         check_output({tag, ".hold.res_valid"}, 32'(res_valid), 32'd1);
         check_output({tag, ".hold.res_data"},  32'(res_data),  exp_res);
         check_output({tag, ".hold.job_ready"}, 32'(job_ready), 32'd0);
      end
      res_ready = 1'b1;
      step();
      job_valid = 1'b0;
      res_ready = 1'b0;
      check_output({tag, ".release.res_valid"}, 32'(res_valid), 32'd0);
      check_output({tag, ".release.job_ready"}, 32'(job_ready), 32'd1);
      if (hold > 0) begin
         step();
         check_output({tag, ".not_queued.job_ready"}, 32'(job_ready), 32'd1);
      end
   endtask

   initial begin
      reset = 1'b1;
      job_valid = 1'b0; job_op = 1'b0; res_ready = 1'b0;
      job_a = '0; job_x = '0; job_b = '0; job_c = '0;
      #1;
      check_output("reset.job_ready", 32'(job_ready), 32'd1);
      check_output("reset.res_valid", 32'(res_valid), 32'd0);
      check_output("reset.res_data",  32'(res_data),  32'd0);
      check_output("reset.res_op",    32'(res_op),    32'd0);
      check_mac("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;
      step();

      apply_stimulus("tri_basic", 1'b1, 8'd5, 8'd3, 8'd2, 8'd1, 0);
      apply_stimulus("tri_b2b",   1'b1, 8'd9, 8'd8, 8'd7, 8'd6, 0);
      apply_stimulus("sop_b2b",   1'b0, 8'd5, 8'd3, 8'd2, 8'd1, 0);
      apply_stimulus("tri_max",   1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 0);
      apply_stimulus("sop_max",   1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 0);
      apply_stimulus("backpress", 1'b0, 8'd17, 8'd4, 8'd10, 8'd11, 5);

      // Abort a TRI job while it is in ISSUE2.
      wait_ready("abort");
      job_valid = 1'b1; job_op = 1'b1;
      job_a = 8'd9; job_x = 8'd8; job_b = 8'd7; job_c = 8'd6;
      step();
      job_valid = 1'b0;
      step();
      check_output("abort.in_issue2.mulmux", 32'(mac_mul_input_mux), 32'd1);
      reset = 1'b1;
      #1;
      check_output("abort.job_ready", 32'(job_ready), 32'd1);
      check_output("abort.res_valid", 32'(res_valid), 32'd0);
      check_output("abort.res_data",  32'(res_data),  32'd0);
      check_output("abort.res_op",    32'(res_op),    32'd0);
      check_mac("abort", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_output("abort.no_res_valid", 32'(res_valid), 32'd0);
      end
      apply_stimulus("after_abort", 1'b0, 8'd2, 8'd3, 8'd4, 8'd5, 0);

      for (int n = 0; n < 24; n++) begin
         apply_stimulus($sformatf("rand%0d", n), 1'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
